// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 convolution window generator.
interface conv_window_gen_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FM_DEPTH = 64
);
    logic                                   verticle_sync;
    logic                                   mode_in;
    logic                                   stride_sel;
    logic                                   data_in_valid;
    logic [FM_DEPTH-1:0][DATA_W-1:0]        data_in;
    logic                                   win_valid;
    logic [FM_DEPTH-1:0][8:0][DATA_W-1:0]   win;
    logic [FM_DEPTH-1:0][3:0][DATA_W-1:0]   res;
    logic                                   vs_next;
    logic                                   err;

    // Upstream pixel source / window consumer
    modport master (
        output verticle_sync, mode_in, stride_sel, data_in_valid, data_in,
        input  win_valid, win, res, vs_next, err
    );

    // Window generator side
    modport slave (
        input  verticle_sync, mode_in, stride_sel, data_in_valid, data_in,
        output win_valid, win, res, vs_next, err
    );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 zero-padded convolution window generator with two per-channel line
// buffers, stride 1/2 and an internal flush for the bottom padding row.
module conv_window_gen #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FM_DEPTH  = 64,
    parameter int unsigned FM_WIDTH  = 56,
    parameter int unsigned FM_HEIGHT = 56,
    parameter int unsigned FLUSH_GAP = 8
) (
    input  logic              clk,
    input  logic              rstn,
    conv_window_gen_if.slave  bus
);
    localparam int unsigned MAX_DIM = (FM_WIDTH > FM_HEIGHT) ? FM_WIDTH : FM_HEIGHT;
    localparam int unsigned CW      = $clog2(MAX_DIM + 1);
    localparam int unsigned AW      = $clog2(FM_WIDTH);
    localparam int unsigned GW      = $clog2(FLUSH_GAP + 1);
    // Last emitted centre in stride 2 is the largest even row/column
    localparam int unsigned LAST_Y2 = ((FM_HEIGHT - 1) / 2) * 2;
    localparam int unsigned LAST_X2 = ((FM_WIDTH - 1) / 2) * 2;

    typedef logic [FM_DEPTH-1:0][DATA_W-1:0]      pix_t;
    typedef logic [FM_DEPTH-1:0][8:0][DATA_W-1:0] win_t;
    typedef logic [FM_DEPTH-1:0][3:0][DATA_W-1:0] res_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state;
    logic [CW-1:0]   row;
    logic [CW-1:0]   col;
    logic            vcol;      // next cycle is the automatic virtual column
    logic [GW-1:0]   gap;
    logic            stride;
    win_t            sr;        // sliding 3x3 column window
    pix_t            lb1 [FM_WIDTH];   // row r-1
    pix_t            lb2 [FM_WIDTH];   // row r-2

    logic            active;
    logic            go;
    logic            bad;
    logic            emit;
    logic            last;
    logic            real_col;
    logic            lb_we;
    logic [AW-1:0]   addr;
    pix_t            top;
    pix_t            mid;
    pix_t            bot;
    win_t            sr_n;
    res_t            res_n;

    // Position sequencing decode and new-column selection with edge zeroing
    always_comb begin
        active   = bus.mode_in && !bus.verticle_sync;
        go       = 1'b0;
        if (state == RUN) begin
            go = active && (vcol || bus.data_in_valid);
        end else if (state == FLUSH) begin
            go = active && (gap == '0);
        end
        bad      = bus.data_in_valid && (state != RUN || vcol);
        lb_we    = go && state == RUN && !vcol;
        real_col = col < CW'(FM_WIDTH);
        addr     = real_col ? AW'(col) : '0;
        top      = (row >= CW'(2) && real_col) ? lb2[addr] : '0;
        mid      = (row != '0 && real_col) ? lb1[addr] : '0;
        bot      = (state == RUN && !vcol) ? bus.data_in : '0;
        emit     = go && row != '0 && col != '0 && (!stride || (row[0] && col[0]));
        last     = stride ? (row == CW'(LAST_Y2 + 1) && col == CW'(LAST_X2 + 1))
                          : (row == CW'(FM_HEIGHT) && col == CW'(FM_WIDTH));
    end

    // Shift the window one column left; column 0 restarts with left padding
    always_comb begin
        sr_n  = '0;
        res_n = '0;
        for (int ch = 0; ch < int'(FM_DEPTH); ch++) begin
            for (int dy = 0; dy < 3; dy++) begin
                sr_n[ch][3*dy]   = (col == '0) ? '0 : sr[ch][3*dy+1];
                sr_n[ch][3*dy+1] = (col == '0) ? '0 : sr[ch][3*dy+2];
            end
            sr_n[ch][2]  = top[ch];
            sr_n[ch][5]  = mid[ch];
            sr_n[ch][8]  = bot[ch];
            res_n[ch][0] = sr_n[ch][4];
            res_n[ch][1] = sr_n[ch][5];
            res_n[ch][2] = sr_n[ch][7];
            res_n[ch][3] = sr_n[ch][8];
        end
    end

    // Line buffers shift one row down on every real pixel
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb2[addr] <= lb1[addr];
            lb1[addr] <= bus.data_in;
        end
    end

    // Control FSM, position counters and registered window outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            vcol          <= 1'b0;
            gap           <= '0;
            stride        <= 1'b0;
            sr            <= '0;
            bus.win_valid <= 1'b0;
            bus.win       <= '0;
            bus.res       <= '0;
            bus.vs_next   <= 1'b0;
            bus.err       <= 1'b0;
        end else if (!bus.mode_in) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            vcol          <= 1'b0;
            gap           <= '0;
            sr            <= '0;
            bus.win_valid <= 1'b0;
            bus.win       <= '0;
            bus.res       <= '0;
            bus.vs_next   <= 1'b0;
            if (bus.verticle_sync) bus.err <= 1'b0;
        end else if (bus.verticle_sync) begin
            state         <= RUN;
            row           <= '0;
            col           <= '0;
            vcol          <= 1'b0;
            gap           <= '0;
            stride        <= bus.stride_sel;
            bus.win_valid <= 1'b0;
            bus.vs_next   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.win_valid <= 1'b0;
            bus.vs_next   <= 1'b0;
            if (bad) bus.err <= 1'b1;
            if (go) begin
                sr <= sr_n;
                if (emit) begin
                    bus.win       <= sr_n;
                    bus.res       <= res_n;
                    bus.win_valid <= 1'b1;
                    bus.vs_next   <= last;
                end
                case (state)
                    RUN: begin
                        if (vcol) begin
                            vcol <= 1'b0;
                            col  <= '0;
                            if (row == CW'(FM_HEIGHT - 1)) begin
                                row   <= CW'(FM_HEIGHT);
                                state <= FLUSH;
                                gap   <= GW'(FLUSH_GAP - 1);
                            end else begin
                                row <= row + CW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                            if (col == CW'(FM_WIDTH - 1)) vcol <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        gap <= GW'(FLUSH_GAP - 1);
                        if (col == CW'(FM_WIDTH)) begin
                            state <= IDLE;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end else if (state == FLUSH) begin
                gap <= gap - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: directed frames plus random frames
// compared against a window model computed straight from the frame array.
module tb_conv_window_gen;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FM_DEPTH  = 2;
    localparam int unsigned FM_WIDTH  = 4;
    localparam int unsigned FM_HEIGHT = 4;
    localparam int unsigned FLUSH_GAP = 8;
    localparam int unsigned WB        = FM_DEPTH * 9 * DATA_W;

    typedef logic [FM_DEPTH-1:0][8:0][DATA_W-1:0] win_t;
    typedef logic [FM_DEPTH-1:0][3:0][DATA_W-1:0] res_t;
    typedef int nine_t [9];
    typedef int four_t [4];

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv_window_gen_if #(.DATA_W(DATA_W), .FM_DEPTH(FM_DEPTH)) bus ();

    conv_window_gen #(
        .DATA_W(DATA_W), .FM_DEPTH(FM_DEPTH), .FM_WIDTH(FM_WIDTH),
        .FM_HEIGHT(FM_HEIGHT), .FLUSH_GAP(FLUSH_GAP)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   vs_cnt   = 0;
    int   px11_cyc = 0;
    win_t win_q [$];
    res_t res_q [$];
    logic vs_q  [$];
    int   cyc_q [$];
    logic [DATA_W-1:0] frm [FM_HEIGHT][FM_WIDTH][FM_DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every emitted window with its cycle stamp
    always @(negedge clk) begin
        if (bus.win_valid) begin
            win_q.push_back(bus.win);
            res_q.push_back(bus.res);
            vs_q.push_back(bus.vs_next);
            cyc_q.push_back(cyc);
        end
        if (bus.vs_next) vs_cnt = vs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference window: element (y+dy-1, x+dx-1), zero outside the frame
    function automatic win_t model_win(input int y, input int x);
        win_t w = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                int yy = y + dy - 1;
                int xx = x + dx - 1;
                if (yy >= 0 && yy < int'(FM_HEIGHT) && xx >= 0 && xx < int'(FM_WIDTH))
                    for (int ch = 0; ch < int'(FM_DEPTH); ch++)
                        w[ch][3*dy+dx] = frm[yy][xx][ch];
            end
        end
        return w;
    endfunction

    function automatic res_t model_res(input win_t w);
        res_t r = '0;
        for (int ch = 0; ch < int'(FM_DEPTH); ch++) begin
            r[ch][0] = w[ch][4];
            r[ch][1] = w[ch][5];
            r[ch][2] = w[ch][7];
            r[ch][3] = w[ch][8];
        end
        return r;
    endfunction

    // Literal window: ch0 as given, ch1 = ch0+100 on non-zero entries
    function automatic win_t lit_win(input nine_t v);
        win_t w = '0;
        for (int k = 0; k < 9; k++) begin
            w[0][k] = DATA_W'(v[k]);
            w[1][k] = (v[k] == 0) ? '0 : DATA_W'(v[k] + 100);
        end
        return w;
    endfunction

    function automatic res_t lit_res(input four_t v);
        res_t r = '0;
        for (int k = 0; k < 4; k++) begin
            r[0][k] = DATA_W'(v[k]);
            r[1][k] = DATA_W'(v[k] + 100);
        end
        return r;
    endfunction

    task automatic fill_pattern(input int base);
        for (int r = 0; r < int'(FM_HEIGHT); r++)
            for (int c = 0; c < int'(FM_WIDTH); c++) begin
                frm[r][c][0] = DATA_W'(16 * r + c + 1 + base);
                frm[r][c][1] = DATA_W'(16 * r + c + 1 + base + 100);
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < int'(FM_HEIGHT); r++)
            for (int c = 0; c < int'(FM_WIDTH); c++)
                for (int ch = 0; ch < int'(FM_DEPTH); ch++)
                    frm[r][c][ch] = DATA_W'($urandom);
    endtask

    task automatic clear_q();
        win_q.delete();
        res_q.delete();
        vs_q.delete();
        cyc_q.delete();
    endtask

    task automatic start_frame(input logic s);
        bus.verticle_sync = 1'b1;
        bus.mode_in       = 1'b1;
        bus.stride_sel    = s;
        tick();
        bus.verticle_sync = 1'b0;
    endtask

    task automatic send_pixel(input int r, input int c, input int g);
        for (int ch = 0; ch < int'(FM_DEPTH); ch++) bus.data_in[ch] = frm[r][c][ch];
        if (r == 1 && c == 1) px11_cyc = cyc;
        bus.data_in_valid = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;
        for (int i = 1; i < g; i++) tick();
    endtask

    // First n raster pixels; never a pixel in the cycle after a row end
    task automatic send_pixels(input int n, input int gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int r = i / int'(FM_WIDTH);
            int c = i % int'(FM_WIDTH);
            int g = rnd ? int'($urandom_range(1, 3)) : gap;
            if (c == int'(FM_WIDTH) - 1 && g < 2) g = 2;
            send_pixel(r, c, g);
        end
    endtask

    task automatic wait_end(input int vs0);
        int n = 0;
        while (vs_cnt == vs0 && n < 400) begin
            tick();
            n++;
        end
        chk("frame_end_vs_next", WB'(vs_cnt - vs0), WB'(1));
    endtask

    task automatic check_frame(input logic s);
        win_t ew [$];
        for (int y = 0; y < int'(FM_HEIGHT); y++)
            for (int x = 0; x < int'(FM_WIDTH); x++)
                if (!s || (y % 2 == 0 && x % 2 == 0)) ew.push_back(model_win(y, x));
        chk("win_count", WB'(win_q.size()), WB'(ew.size()));
        for (int i = 0; i < ew.size() && i < win_q.size(); i++) begin
            chk($sformatf("win[%0d]", i), WB'(win_q[i]), WB'(ew[i]));
            chk($sformatf("res[%0d]", i), WB'(res_q[i]), WB'(model_res(ew[i])));
            chk($sformatf("vs_next[%0d]", i), WB'(vs_q[i]), WB'(i == ew.size() - 1));
        end
    endtask

    int    vs0;
    int    nq;
    logic  s;
    nine_t lv;
    four_t lr;

    initial begin
        rstn              = 1'b1;
        bus.verticle_sync = 1'b0;
        bus.mode_in       = 1'b0;
        bus.stride_sel    = 1'b0;
        bus.data_in_valid = 1'b0;
        bus.data_in       = '0;
        #2 rstn = 1'b0;
        repeat (3) tick();
        chk("rst_win_valid", WB'(bus.win_valid), WB'(0));
        chk("rst_vs_next", WB'(bus.vs_next), WB'(0));
        chk("rst_err", WB'(bus.err), WB'(0));
        chk("rst_win", WB'(bus.win), WB'(0));
        chk("rst_res", WB'(bus.res), WB'(0));
        rstn = 1'b1;
        tick();

        // Stride 1 frame with the reference pattern
        fill_pattern(0);
        clear_q();
        vs0 = vs_cnt;
        start_frame(1'b0);
        send_pixels(16, 3, 1'b0);
        wait_end(vs0);
        check_frame(1'b0);
        chk("s1_err", WB'(bus.err), WB'(0));
        if (win_q.size() >= 16) begin
            lv = '{0, 0, 0, 0, 1, 2, 0, 17, 18};
            chk("s1_first_win", WB'(win_q[0]), WB'(lit_win(lv)));
            chk("s1_first_latency", WB'(cyc_q[0]), WB'(px11_cyc + 1));
            lv = '{0, 0, 0, 3, 4, 0, 19, 20, 0};
            chk("s1_vcol_win", WB'(win_q[3]), WB'(lit_win(lv)));
            chk("s1_vcol_spacing", WB'(cyc_q[3] - cyc_q[2]), WB'(1));
            lv = '{35, 36, 0, 51, 52, 0, 0, 0, 0};
            chk("s1_last_win", WB'(win_q[15]), WB'(lit_win(lv)));
        end

        // Stride 2 frame
        clear_q();
        vs0 = vs_cnt;
        start_frame(1'b1);
        send_pixels(16, 3, 1'b0);
        wait_end(vs0);
        check_frame(1'b1);
        if (res_q.size() >= 4) begin
            lr = '{35, 36, 51, 52};
            chk("s2_last_res", WB'(res_q[3]), WB'(lit_res(lr)));
        end

        // Abort after pixel (2,1), restart with shifted values
        clear_q();
        vs0 = vs_cnt;
        start_frame(1'b0);
        send_pixels(10, 3, 1'b0);
        fill_pattern(50);
        clear_q();
        start_frame(1'b0);
        chk("abort_no_vs_next", WB'(vs_cnt), WB'(vs0));
        send_pixels(16, 3, 1'b0);
        wait_end(vs0);
        check_frame(1'b0);
        if (win_q.size() >= 1) begin
            lv = '{0, 0, 0, 0, 51, 52, 0, 67, 68};
            chk("abort_first_win", WB'(win_q[0]), WB'(lit_win(lv)));
        end

        // Random frames, random stride and pixel spacing
        for (int f = 0; f < 4; f++) begin
            fill_random();
            s = 1'($urandom_range(0, 1));
            clear_q();
            vs0 = vs_cnt;
            start_frame(s);
            send_pixels(16, 1, 1'b1);
            wait_end(vs0);
            check_frame(s);
            chk("rand_err", WB'(bus.err), WB'(0));
        end

        // Pixel during FLUSH, then mode_in dropped mid-FLUSH
        fill_pattern(0);
        clear_q();
        vs0 = vs_cnt;
        start_frame(1'b0);
        send_pixels(16, 2, 1'b0);
        tick();
        bus.data_in_valid = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;
        chk("flush_pixel_err", WB'(bus.err), WB'(1));
        repeat (10) tick();
        bus.mode_in = 1'b0;
        tick();
        chk("mode_drop_win_valid", WB'(bus.win_valid), WB'(0));
        chk("mode_drop_win", WB'(bus.win), WB'(0));
        chk("mode_drop_res", WB'(bus.res), WB'(0));
        chk("mode_drop_vs_next", WB'(bus.vs_next), WB'(0));
        nq = win_q.size();
        repeat (60) tick();
        chk("mode_drop_no_windows", WB'(win_q.size()), WB'(nq));
        chk("mode_drop_no_vs", WB'(vs_cnt), WB'(vs0));
        chk("err_held", WB'(bus.err), WB'(1));
        bus.mode_in = 1'b1;
        repeat (40) tick();
        chk("idle_no_windows", WB'(win_q.size()), WB'(nq));
        chk("err_held_idle", WB'(bus.err), WB'(1));
        start_frame(1'b0);
        chk("vsync_clears_err", WB'(bus.err), WB'(0));

        // Pixel in IDLE with mode_in=1
        bus.mode_in = 1'b0;
        tick();
        bus.mode_in = 1'b1;
        tick();
        bus.data_in_valid = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;
        chk("idle_pixel_err", WB'(bus.err), WB'(1));
        tick();
        chk("idle_pixel_no_window", WB'(win_q.size()), WB'(nq));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
